// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch vs load/store, serialises
// accesses onto the 8-bit RAM/IO port and assembles little-endian results.
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        src_lsb_q, src_lsb_d;
  logic        last_lsb_q, last_lsb_d;

  logic        if_done_d, lsb_done_d, mem_wr_d;
  logic [31:0] if_data_d, lsb_rdata_d, mem_a_d;
  logic [7:0]  mem_dout_d;

  // The RAM keeps sampling the frozen address while paused, so the byte that
  // was in flight when rdy_in dropped is saved and used on the first resumed edge.
  logic        run_q;
  logic [7:0]  din_save_q;
  logic [7:0]  byte_in;

  logic        pick_lsb, stall;
  logic [2:0]  len_n, wr_next;
  logic [31:0] asm_word, wshift;

  assign byte_in = run_q ? mem_din : din_save_q;

  always_comb begin
    case (lsb_len)
      2'd0:    len_n = 3'd1;
      2'd1:    len_n = 3'd2;
      default: len_n = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    src_lsb_d   = src_lsb_q;
    last_lsb_d  = last_lsb_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data;
    lsb_rdata_d = lsb_rdata;
    mem_a_d     = mem_a;
    mem_dout_d  = mem_dout;
    mem_wr_d    = mem_wr;
    pick_lsb    = lsb_req && (!if_req || !last_lsb_q);
    stall       = (base_q[17:16] == IO_HI) && io_buffer_full;
    asm_word    = buf_q | ({24'b0, byte_in} << {idx_q - 3'd2, 3'b000});
    wr_next     = mem_wr ? idx_q + 3'd1 : idx_q;
    wshift      = wdata_q >> {wr_next, 3'b000};

    case (state_q)
      IDLE: begin
        if (!clear_in && (if_req || lsb_req)) begin
          src_lsb_d  = pick_lsb;
          last_lsb_d = pick_lsb;
          base_d     = pick_lsb ? lsb_addr : if_addr;
          wdata_d    = lsb_wdata;
          buf_d      = '0;
          n_d        = pick_lsb ? len_n : 3'd4;
          mem_a_d    = pick_lsb ? lsb_addr : if_addr;
          mem_dout_d = lsb_wdata[7:0];
          if (pick_lsb && lsb_wr) begin
            state_d  = WRITE;
            idx_d    = 3'd0;
            mem_wr_d = !((lsb_addr[17:16] == IO_HI) && io_buffer_full);
          end else begin
            // In READ, idx counts edges since grant: address k goes out at
            // edge k, byte k is captured at edge k+2.
            state_d  = READ;
            idx_d    = 3'd1;
            mem_wr_d = 1'b0;
          end
        end
      end
      READ: begin
        if (clear_in) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          mem_a_d = '0;
        end else begin
          if (idx_q >= 3'd2) buf_d = asm_word;
          if (idx_q == n_q + 3'd1) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            mem_a_d = '0;
            if (src_lsb_q) begin
              lsb_rdata_d = asm_word;
              lsb_done_d  = 1'b1;
            end else begin
              if_data_d = asm_word;
              if_done_d = 1'b1;
            end
          end else begin
            if (idx_q < n_q) mem_a_d = base_q + {29'b0, idx_q};
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WRITE: begin
        // A byte is retired only on an edge where it was driven with mem_wr=1;
        // a stalled byte is re-driven until it goes out.
        if (mem_wr && (idx_q == n_q - 3'd1)) begin
          state_d    = IDLE;
          idx_d      = 3'd0;
          mem_a_d    = '0;
          mem_wr_d   = 1'b0;
          lsb_done_d = 1'b1;
        end else begin
          idx_d      = wr_next;
          mem_a_d    = base_q + {29'b0, wr_next};
          mem_dout_d = wshift[7:0];
          mem_wr_d   = !stall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      src_lsb_q  <= 1'b0;
      last_lsb_q <= 1'b0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
      if_data    <= '0;
      lsb_rdata  <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      busy_out   <= 1'b0;
      run_q      <= 1'b0;
      din_save_q <= '0;
    end else begin
      run_q <= rdy_in;
      if (run_q) din_save_q <= mem_din;
      if (rdy_in) begin
        state_q    <= state_d;
        idx_q      <= idx_d;
        n_q        <= n_d;
        base_q     <= base_d;
        wdata_q    <= wdata_d;
        buf_q      <= buf_d;
        src_lsb_q  <= src_lsb_d;
        last_lsb_q <= last_lsb_d;
        if_done    <= if_done_d;
        lsb_done   <= lsb_done_d;
        if_data    <= if_data_d;
        lsb_rdata  <= lsb_rdata_d;
        mem_a      <= mem_a_d;
        mem_dout   <= mem_dout_d;
        mem_wr     <= mem_wr_d;
        busy_out   <= (state_d != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: small byte RAM model, hand-computed expectations.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req, lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        busy_out;

  logic [7:0]  ram [0:1023];
  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // RAM samples the address every edge; read data appears one cycle later.
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h201] = 8'hFF; ram[10'h202] = 8'h80;
    ram[10'h204] = 8'h34; ram[10'h205] = 8'hA2;
    mem_din = 8'h00;
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = 2'd0; lsb_wdata = '0;
    io_buffer_full = 1'b0;
    step(); step();
    rst_in = 1'b0;
    chk("rst_busy", {31'b0, busy_out}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);

    // Fetch word at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("f_mem_a0", mem_a, 32'h100);
    chk("f_busy", {31'b0, busy_out}, 32'd1);
    step(); chk("f_mem_a1", mem_a, 32'h101);
    step(); chk("f_mem_a2", mem_a, 32'h102);
    step(); chk("f_mem_a3", mem_a, 32'h103);
    step(); chk("f_done_early", {31'b0, if_done}, 32'd0);
    step();
    chk("f_done", {31'b0, if_done}, 32'd1);
    chk("f_data", if_data, 32'h0000_0513);
    chk("f_busy_end", {31'b0, busy_out}, 32'd0);
    chk("f_mem_a_end", mem_a, 32'd0);
    if_req = 1'b0;
    step(); chk("f_done_pulse", {31'b0, if_done}, 32'd0);

    // Load half at 0x201
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h201; lsb_len = 2'd1;
    step(); chk("lh_mem_a0", mem_a, 32'h201);
    step(); step(); chk("lh_done_early", {31'b0, lsb_done}, 32'd0);
    step();
    chk("lh_done", {31'b0, lsb_done}, 32'd1);
    chk("lh_rdata", lsb_rdata, 32'h0000_80FF);
    chk("lh_if_hold", if_data, 32'h0000_0513);
    lsb_req = 1'b0;
    step();

    // Store word to IO window with buffer full during byte 1
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_len = 2'd2;
    lsb_wdata = 32'h1234_5678;
    step();
    chk("sw_b0", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'h78});
    io_buffer_full = 1'b1;
    step(); chk("sw_stall1", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b0, 8'h56});
    step(); chk("sw_stall2", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b0, 8'h56});
    io_buffer_full = 1'b0;
    step(); chk("sw_b1", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'h56});
    step(); chk("sw_b2", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'h34});
    chk("sw_a2", mem_a, 32'h0003_0002);
    step(); chk("sw_b3", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'h12});
    step();
    chk("sw_done", {31'b0, lsb_done}, 32'd1);
    chk("sw_wr_end", {31'b0, mem_wr}, 32'd0);
    chk("sw_mem_a_end", mem_a, 32'd0);
    lsb_req = 1'b0;
    step();

    // Arbitration after reset: LSB, then IF, then LSB again
    rst_in = 1'b1; step(); rst_in = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h201; lsb_len = 2'd1;
    step(); chk("arb_first_lsb", mem_a, 32'h201);
    step(); step(); step();
    chk("arb_lsb_done", {30'b0, lsb_done, if_done}, 32'd2);
    step(); chk("arb_then_if", mem_a, 32'h100);
    step(); step(); step(); step(); step();
    chk("arb_if_done", {30'b0, lsb_done, if_done}, 32'd1);
    chk("arb_if_data", if_data, 32'h0000_0513);
    step(); chk("arb_lsb_again", mem_a, 32'h201);
    if_req = 1'b0;
    step(); step(); step();
    chk("arb_lsb2_done", {31'b0, lsb_done}, 32'd1);
    lsb_req = 1'b0;
    step();

    // Clear at fetch byte 2: abort with no done pulse
    if_req = 1'b1; if_addr = 32'h100;
    step(); step(); step();
    chk("clr_at_b2", mem_a, 32'h102);
    clear_in = 1'b1; if_req = 1'b0;
    step();
    chk("clr_busy", {31'b0, busy_out}, 32'd0);
    chk("clr_no_done", {31'b0, if_done}, 32'd0);
    clear_in = 1'b0;
    step(); chk("clr_no_done2", {31'b0, if_done}, 32'd0);

    // Clear during store byte: store still completes
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h50; lsb_len = 2'd0; lsb_wdata = 32'h0000_00AB;
    step(); chk("clr_st_b0", {23'b0, mem_wr, mem_dout}, {23'b0, 1'b1, 8'hAB});
    clear_in = 1'b1;
    step(); chk("clr_st_done", {31'b0, lsb_done}, 32'd1);
    lsb_req = 1'b0;
    // Clear held in IDLE blocks the grant
    if_req = 1'b1;
    step(); chk("clr_idle_nogrant", {31'b0, busy_out}, 32'd0);
    clear_in = 1'b0; if_req = 1'b0;
    step();
    chk("ram_store", {24'b0, ram[10'h50]}, 32'h0000_00AB);

    // rdy_in low for 3 cycles mid-load (clear ignored while paused)
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h204; lsb_len = 2'd1;
    step(); step();
    chk("rdy_a1", mem_a, 32'h205);
    rdy_in = 1'b0; clear_in = 1'b1;
    step(); step(); step();
    chk("rdy_hold_a", mem_a, 32'h205);
    chk("rdy_hold_busy", {31'b0, busy_out}, 32'd1);
    rdy_in = 1'b1; clear_in = 1'b0;
    step(); chk("rdy_done_early", {31'b0, lsb_done}, 32'd0);
    step();
    chk("rdy_done", {31'b0, lsb_done}, 32'd1);
    chk("rdy_rdata", lsb_rdata, 32'h0000_A234);
    lsb_req = 1'b0;
    step();

    // Reset mid-write (with rdy low) clears every output
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h40; lsb_len = 2'd2; lsb_wdata = 32'hCAFE_F00D;
    step(); step();
    chk("rstw_active", {31'b0, mem_wr}, 32'd1);
    rst_in = 1'b1; rdy_in = 1'b0; lsb_req = 1'b0;
    step();
    chk("rstw_wr", {31'b0, mem_wr}, 32'd0);
    chk("rstw_a_dout", {mem_a[23:0], mem_dout}, 32'd0);
    chk("rstw_busy", {31'b0, busy_out}, 32'd0);
    chk("rstw_data", if_data | lsb_rdata, 32'd0);
    rst_in = 1'b0; rdy_in = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
